// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch stage and the instruction memory.
// The request and address are held by the master until the memory acknowledges.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the single-cycle RV32I core: holds the PC, fetches over a
// variable-latency req/ack handshake and presents the decoded fields until the core retires them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master imem,
    input  logic        advance,
    input  logic        NextPCSrc,
    input  logic [31:0] TargetPC,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    output logic [6:0]  OpCode,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic        Misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic        req_r;
    logic        misaligned_r;

    // Fetch FSM; request and valid flags are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            instr_r      <= NOP_INSTR;
            valid_r      <= 1'b0;
            req_r        <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_REQ;
                    req_r   <= 1'b1;
                    valid_r <= 1'b0;
                end
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        instr_r <= imem.imem_rdata;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= ST_VALID;
                    end else begin
                        req_r   <= 1'b1;
                        valid_r <= 1'b0;
                        state_r <= ST_REQ;
                    end
                end
                ST_VALID: begin
                    if (advance) begin
                        // Retiring clears Instr so the control unit decodes a harmless addi while fetching.
                        instr_r <= NOP_INSTR;
                        valid_r <= 1'b0;
                        if (!NextPCSrc) begin
                            pc_r    <= pc_r + 32'd4;
                            req_r   <= 1'b1;
                            state_r <= ST_REQ;
                        end else if (TargetPC[1:0] == 2'b00) begin
                            pc_r    <= TargetPC;
                            req_r   <= 1'b1;
                            state_r <= ST_REQ;
                        end else begin
                            misaligned_r <= 1'b1;
                            req_r        <= 1'b0;
                            state_r      <= ST_TRAP;
                        end
                    end else begin
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                        state_r <= ST_VALID;
                    end
                end
                ST_TRAP: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= ST_TRAP;
                end
                default: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    instr_r <= NOP_INSTR;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;

    assign Instr      = instr_r;
    assign PC         = pc_r;
    assign PCPlus4    = pc_r + 32'd4;
    assign InstrValid = valid_r;
    assign Misaligned = misaligned_r;

    // Decoded fields are plain slices of the registered word.
    assign OpCode = instr_r[6:0];
    assign Funct3 = instr_r[14:12];
    assign Funct7 = instr_r[31:25];
    assign Rs1    = instr_r[19:15];
    assign Rs2    = instr_r[24:20];
    assign Rd     = instr_r[11:7];

endmodule
